// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read side with a synchronised write pointer and a first-word-fall-through output register
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_SIZE:0]    wptr_gray,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_SIZE-1:0]  r_addr,
  output logic [ADDR_SIZE:0]    rptr_gray,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [ADDR_SIZE:0]    rd_level
);
  logic [ADDR_SIZE:0]   wq1, wq2, wbin, rbin, rbin_next, diff;
  logic [ADDR_SIZE+1:0] sum;
  logic                 mem_empty, fetch;
  always_comb begin
    wbin = wq2;
    for (int i = ADDR_SIZE - 1; i >= 0; i--) wbin[i] = wbin[i+1] ^ wq2[i];
  end
  assign mem_empty = wq2 == rptr_gray;
  // rd_ready only enables the fetch; rd_valid/rd_data/r_addr all come from flops
  assign fetch     = ~mem_empty & (~rd_valid | rd_ready);
  assign rbin_next = rbin + (ADDR_SIZE+1)'(fetch);
  assign r_addr    = rbin[ADDR_SIZE-1:0];
  assign empty     = ~rd_valid;
  assign diff      = wbin - rbin;
  assign sum       = {1'b0, diff} + (ADDR_SIZE+2)'(rd_valid);
  assign rd_level  = sum[ADDR_SIZE+1] ? '1 : sum[ADDR_SIZE:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wq1       <= '0;
      wq2       <= '0;
      rbin      <= '0;
      rptr_gray <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      wq1       <= wptr_gray;
      wq2       <= wq1;
      rbin      <= rbin_next;
      rptr_gray <= (rbin_next >> 1) ^ rbin_next;
      rd_valid  <= fetch | (rd_valid & ~rd_ready);
      rd_data   <= fetch ? mem_data : rd_data;
    end
  end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: models fifo_mem and the writer's pointer; scoreboard queue holds words in write order
module tb_fifo_rd_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] wptr_gray = '0;
  logic [7:0] mem_data;
  logic [2:0] r_addr;
  logic [3:0] rptr_gray;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       empty;
  logic [3:0] rd_level;
  logic [7:0] mem [8];
  logic [3:0] wb = '0;
  logic [7:0] q [$];
  logic [7:0] exp;
  int checks = 0;
  int failures = 0;

  fifo_rd_ctrl #(.DATA_WIDTH(8), .ADDR_SIZE(3)) dut (
    .clk(clk), .rst(rst), .wptr_gray(wptr_gray), .mem_data(mem_data),
    .r_addr(r_addr), .rptr_gray(rptr_gray), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .empty(empty), .rd_level(rd_level)
  );

  always #5 clk = ~clk;
  assign mem_data = mem[r_addr];

  task tick;
    @(posedge clk);
    #1;
  endtask

  task write_word(input logic [7:0] d);
    mem[wb[2:0]] = d;
    q.push_back(d);
    wb = wb + 4'd1;
    wptr_gray = wb ^ (wb >> 1);
  endtask

  task apply_reset;
    rst = 1'b1;
    rd_ready = 1'b0;
    wb = '0;
    wptr_gray = '0;
    q.delete();
    tick;
    rst = 1'b0;
  endtask

  task test_reset;
    rst = 1'b1;
    #3;
    checks++;
    if ({rd_valid, empty, rptr_gray, r_addr, rd_level, rd_data} !== {1'b1 ^ 1'b1, 1'b1, 4'h0, 3'h0, 4'h0, 8'h00}) begin
      failures++;
      $display("FAIL reset_async got v=%b e=%b rp=%h ra=%h lvl=%0d d=%h want v=0 e=1 rp=0 ra=0 lvl=0 d=00",
               rd_valid, empty, rptr_gray, r_addr, rd_level, rd_data);
    end
    tick;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if ({rd_valid, empty, rptr_gray, r_addr, rd_level} !== {1'b0, 1'b1, 4'h0, 3'h0, 4'h0}) begin
        failures++;
        $display("FAIL reset_hold[%0d] got v=%b e=%b rp=%h ra=%h lvl=%0d want v=0 e=1 rp=0 ra=0 lvl=0",
                 i, rd_valid, empty, rptr_gray, r_addr, rd_level);
      end
    end
  endtask

  task test_single_word;
    rd_ready = 1'b0;
    write_word(8'hA5);
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL single_latency[%0d] got rd_valid=%b want 0", i, rd_valid);
      end
    end
    tick;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({rd_valid, rd_data, rptr_gray} !== {1'b1, 8'hA5, 4'b0001}) begin
        failures++;
        $display("FAIL single_hold[%0d] got v=%b d=%h rp=%b want v=1 d=a5 rp=0001", i, rd_valid, rd_data, rptr_gray);
      end
      tick;
    end
    rd_ready = 1'b1;
    if (rd_valid && rd_ready) begin
      exp = q.pop_front();
      checks++;
      if (rd_data !== exp) begin
        failures++;
        $display("FAIL single_accept got %h want %h", rd_data, exp);
      end
    end
    tick;
    rd_ready = 1'b0;
    checks++;
    if ({rd_valid, empty} !== 2'b01) begin
      failures++;
      $display("FAIL single_drain got v=%b e=%b want v=0 e=1", rd_valid, empty);
    end
  endtask

  task test_fill;
    apply_reset;
    for (int i = 0; i < 8; i++) begin
      write_word(8'h10 + 8'(i));
      tick;
    end
    repeat (3) tick;
    checks++;
    if ({rd_valid, rd_data, rd_level} !== {1'b1, 8'h10, 4'd8}) begin
      failures++;
      $display("FAIL fill_full got v=%b d=%h lvl=%0d want v=1 d=10 lvl=8", rd_valid, rd_data, rd_level);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = q.pop_front();
      checks++;
      if (!rd_valid || rd_data !== exp) begin
        failures++;
        $display("FAIL fill_burst[%0d] got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp);
      end
      tick;
    end
    checks++;
    if ({rd_valid, rptr_gray} !== {1'b0, 4'b1100}) begin
      failures++;
      $display("FAIL fill_end got v=%b rp=%b want v=0 rp=1100", rd_valid, rptr_gray);
    end
  endtask

  task test_stream;
    int sent, got;
    logic [3:0] prev;
    sent = 0;
    got = 0;
    prev = rptr_gray;
    for (int cyc = 0; cyc < 2000 && got < 40; cyc++) begin
      rd_ready = 1'($urandom_range(0, 1));
      if (sent < 40 && q.size() < 8) begin
        write_word(8'($urandom));
        sent++;
      end
      if (rd_valid && rd_ready) begin
        exp = q.pop_front();
        got++;
        checks++;
        if (rd_data !== exp) begin
          failures++;
          $display("FAIL stream_data[%0d] got %h want %h", got, rd_data, exp);
        end
      end
      tick;
      checks++;
      if ($countones(rptr_gray ^ prev) > 1) begin
        failures++;
        $display("FAIL stream_gray got %b after %b want one-bit step", rptr_gray, prev);
      end
      prev = rptr_gray;
    end
    checks++;
    if (got != 40) begin
      failures++;
      $display("FAIL stream_timeout got %0d words want 40", got);
    end
    rd_ready = 1'b0;
    repeat (3) tick;
    checks++;
    if ({rd_valid, rptr_gray} !== {1'b0, wb ^ (wb >> 1)}) begin
      failures++;
      $display("FAIL stream_end got v=%b rp=%b want v=0 rp=%b", rd_valid, rptr_gray, wb ^ (wb >> 1));
    end
  endtask

  task test_reset_mid;
    apply_reset;
    for (int i = 0; i < 4; i++) begin
      write_word(8'h50 + 8'(i));
      tick;
    end
    repeat (3) tick;
    checks++;
    if ({rd_valid, rd_level} !== {1'b1, 4'd4}) begin
      failures++;
      $display("FAIL midrst_setup got v=%b lvl=%0d want v=1 lvl=4", rd_valid, rd_level);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_valid, empty, rptr_gray, r_addr, rd_level, rd_data} !== {1'b0, 1'b1, 4'h0, 3'h0, 4'h0, 8'h00}) begin
      failures++;
      $display("FAIL midrst_async got v=%b e=%b rp=%h ra=%h lvl=%0d d=%h want v=0 e=1 rp=0 ra=0 lvl=0 d=00",
               rd_valid, empty, rptr_gray, r_addr, rd_level, rd_data);
    end
    wb = '0;
    wptr_gray = '0;
    q.delete();
    tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_idle[%0d] got rd_valid=%b want 0", i, rd_valid);
      end
    end
    write_word(8'h3C);
    repeat (3) tick;
    exp = q.pop_front();
    checks++;
    if ({rd_valid, rd_data} !== {1'b1, exp}) begin
      failures++;
      $display("FAIL midrst_new got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, exp);
    end
  endtask

  task test_level;
    apply_reset;
    for (int i = 0; i < 3; i++) begin
      write_word(8'hC0 + 8'(i));
      tick;
    end
    repeat (3) tick;
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_level !== 4'(3 - i)) begin
        failures++;
        $display("FAIL level[%0d] got %0d want %0d", i, rd_level, 3 - i);
      end
      if (rd_valid && rd_ready) begin
        exp = q.pop_front();
        checks++;
        if (rd_data !== exp) begin
          failures++;
          $display("FAIL level_data[%0d] got %h want %h", i, rd_data, exp);
        end
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_fill;
    test_stream;
    test_reset_mid;
    test_level;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
